// File: rtl/noritsuna_cnt_pkg.sv
// Shared definitions for the programmable counter: control-byte layout,
// write-address map, prescale selects and status-byte bit positions.
package noritsuna_cnt_pkg;

  // Register addresses carried in ui_in[4:3]
  typedef enum logic [1:0] {
    ADDR_COUNT = 2'b00,
    ADDR_MOD   = 2'b01,
    ADDR_CMP   = 2'b10,
    ADDR_CLR   = 2'b11
  } wr_addr_e;

  // Prescale selects carried in ui_in[7:6]
  typedef enum logic [1:0] {
    PSEL_DIV1    = 2'd0,
    PSEL_DIV16   = 2'd1,
    PSEL_DIV256  = 2'd2,
    PSEL_DIVFULL = 2'd3
  } psel_e;

  // Bit positions inside the status byte
  localparam int STAT_TC  = 7;
  localparam int STAT_PWM = 6;
  localparam int STAT_DIR = 5;
  localparam int STAT_EN  = 4;

  // ui_in viewed as a control word; field order matches bit order MSB first
  typedef struct packed {
    psel_e    psel;  // [7:6]
    logic     view;  // [5]
    wr_addr_e addr;  // [4:3]
    logic     wr;    // [2]
    logic     dir;   // [1]
    logic     en;    // [0]
  } ctrl_t;

  // Assemble the status byte; low nibble is always zero
  function automatic logic [7:0] status_byte(input logic tc, input logic pwm,
                                             input logic dir, input logic en);
    logic [7:0] s;
    s           = 8'h00;
    s[STAT_TC]  = tc;
    s[STAT_PWM] = pwm;
    s[STAT_DIR] = dir;
    s[STAT_EN]  = en;
    return s;
  endfunction

endpackage

// File: rtl/noritsuna_prescaler.sv
// Free-running prescaler. Emits a tick whenever the low k bits of the
// counter are all ones, k chosen by psel (0, 4, 8 or PRESC_W).
// clr restarts the count from zero so the next tick is 2^k cycles away.
module noritsuna_prescaler
  import noritsuna_cnt_pkg::*;
#(
  parameter int PRESC_W = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  ena,
  input  logic  clr,
  input  psel_e psel,
  output logic  tick
);

  logic [PRESC_W-1:0] cnt;

  // Running count; holds while the tile is disabled
  always_ff @(posedge clk) begin
    if (!rst_n)     cnt <= '0;
    else if (ena) begin
      if (clr)      cnt <= '0;
      else          cnt <= cnt + PRESC_W'(1);
    end
  end

  // Tick decode from the current count value
  always_comb begin
    tick = 1'b0;
    case (psel)
      PSEL_DIV1:    tick = 1'b1;
      PSEL_DIV16:   tick = &cnt[3:0];
      PSEL_DIV256:  tick = &cnt[7:0];
      PSEL_DIVFULL: tick = &cnt;
      default:      tick = 1'b0;
    endcase
  end

endmodule

// File: rtl/tt_um_noritsuna_prog_counter.sv
// Programmable TinyTapeout counter: prescaled up/down count with modulo
// wrap, sticky terminal-count flag and a count/status output view.
// Optional feature macro: PWM_OUT_EN adds a compare register and a
// registered PWM comparator reported in status bit 6.
module tt_um_noritsuna_prog_counter
  import noritsuna_cnt_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 16
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  ctrl_t            ctrl;
  logic             wr_q;
  logic             wr_edge;
  logic             wr_count;
  logic             wr_mod;
  logic             wr_clr;
  logic [WIDTH-1:0] wr_data;
  logic             tick;
  logic             step;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] modulo;
  logic             tc_evt;
  logic             tc_flag;
  logic             pwm;
  logic             unused_ok;

  assign ctrl    = ctrl_t'(ui_in);
  assign wr_data = uio_in[WIDTH-1:0];

  // The bidirectional pins are all inputs
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  // Upper data bits are unused for narrow counters
  assign unused_ok = &{1'b0, uio_in};

  // Registered write strobe for rising-edge detection
  always_ff @(posedge clk) begin
    if (!rst_n)   wr_q <= 1'b0;
    else if (ena) wr_q <= ctrl.wr;
  end

  // One write per rising edge of wr; nothing happens while the tile is off
  assign wr_edge  = ena & ctrl.wr & ~wr_q;
  assign wr_count = wr_edge & (ctrl.addr == ADDR_COUNT);
  assign wr_mod   = wr_edge & (ctrl.addr == ADDR_MOD);
  assign wr_clr   = wr_edge & (ctrl.addr == ADDR_CLR);

  // A count write restarts the prescaler so the first step is a full period away
  noritsuna_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .clr   (wr_count),
    .psel  (ctrl.psel),
    .tick  (tick)
  );

  assign step = tick & ctrl.en;

  // Next count: a write beats a step; wrap in either direction raises tc_evt
  always_comb begin
    count_nxt = count;
    tc_evt    = 1'b0;
    if (wr_count) begin
      count_nxt = wr_data;
    end else if (step) begin
      if (ctrl.dir) begin
        if (count >= modulo) begin
          count_nxt = '0;
          tc_evt    = 1'b1;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else begin
        if (count == '0) begin
          count_nxt = modulo;
          tc_evt    = 1'b1;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (!rst_n)   count <= '0;
    else if (ena) count <= count_nxt;
  end

  // Modulo register; resets to the full range
  always_ff @(posedge clk) begin
    if (!rst_n)      modulo <= '1;
    else if (wr_mod) modulo <= wr_data;
  end

  // Sticky terminal-count flag; a same-cycle set beats the clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tc_flag <= 1'b0;
    end else if (ena) begin
      if (tc_evt)      tc_flag <= 1'b1;
      else if (wr_clr) tc_flag <= 1'b0;
    end
  end

`ifdef PWM_OUT_EN
  logic             wr_cmp;
  logic [WIDTH-1:0] compare;

  assign wr_cmp = wr_edge & (ctrl.addr == ADDR_CMP);

  // Compare register
  always_ff @(posedge clk) begin
    if (!rst_n)      compare <= '0;
    else if (wr_cmp) compare <= wr_data;
  end

  // Registered comparator: pwm trails count by one cycle
  always_ff @(posedge clk) begin
    if (!rst_n)   pwm <= 1'b0;
    else if (ena) pwm <= (count < compare);
  end
`else
  assign pwm = 1'b0;
`endif

  // Output view: zero-extended count or status byte
  always_comb begin
    uo_out = 8'(count);
    if (ctrl.view) uo_out = status_byte(tc_flag, pwm, ctrl.dir, ctrl.en);
  end

endmodule

// File: tb/tb_tt_um_noritsuna_prog_counter.sv
// Self-checking bench for tt_um_noritsuna_prog_counter (WIDTH 8, PRESC_W 16).
// Directed scenarios plus a long randomized run against a behavioural model.
module tb_tt_um_noritsuna_prog_counter;

  localparam int W  = 8;
  localparam int PW = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_errors = 0;

  // Control fields driven by the tests
  bit       t_en, t_dir, t_wr, t_view;
  bit [1:0] t_addr, t_psel;

  // Reference model state
  int m_count, m_mod, m_cmp, m_presc;
  bit m_tc, m_pwm, m_wrq;

  tt_um_noritsuna_prog_counter #(.WIDTH(W), .PRESC_W(PW)) dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  always #5 clk = ~clk;

  task automatic drive();
    ui_in = {t_psel, t_view, t_addr, t_wr, t_dir, t_en};
  endtask

  // Behavioural model of one clock edge, from the rules of operation
  task automatic model_step();
    int  k, period, oc;
    bit  wedge, tick, tc_set;
    if (!rst_n) begin
      m_count = 0; m_mod = (1 << W) - 1; m_cmp = 0; m_tc = 0;
      m_pwm = 0; m_presc = 0; m_wrq = 0;
    end else if (ena) begin
      oc     = m_count;
      wedge  = t_wr && !m_wrq;
      m_wrq  = t_wr;
      k      = (t_psel == 0) ? 0 : (t_psel == 1) ? 4 : (t_psel == 2) ? 8 : PW;
      period = 1 << k;
      tick   = (m_presc % period) == period - 1;
      m_presc = (wedge && t_addr == 0) ? 0 : (m_presc + 1) % (1 << PW);
      tc_set = 0;
      if (wedge && t_addr == 0) m_count = int'(uio_in) % (1 << W);
      else if (tick && t_en) begin
        if (t_dir) begin
          if (oc >= m_mod) begin m_count = 0; tc_set = 1; end
          else m_count = oc + 1;
        end else begin
          if (oc == 0) begin m_count = m_mod; tc_set = 1; end
          else m_count = oc - 1;
        end
      end
`ifdef PWM_OUT_EN
      m_pwm = oc < m_cmp;
      if (wedge && t_addr == 2) m_cmp = int'(uio_in) % (1 << W);
`endif
      if (wedge && t_addr == 1) m_mod = int'(uio_in) % (1 << W);
      if (tc_set) m_tc = 1;
      else if (wedge && t_addr == 3) m_tc = 0;
    end
  endtask

  function automatic logic [7:0] model_out();
    if (t_view) return {m_tc, m_pwm, t_dir, t_en, 4'b0000};
    return 8'(m_count);
  endfunction

  // Advance one clock; outputs are settled 1 time unit after the edge
  task automatic clk_step();
    drive();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek_view(input bit v);
    t_view = v;
    drive();
    #1;
  endtask

  task automatic do_write(input bit [1:0] a, input logic [7:0] d);
    t_addr = a; uio_in = d; t_wr = 1; clk_step();
    t_wr = 0; clk_step();
  endtask

  task automatic apply_reset();
    t_en = 0; t_dir = 1; t_wr = 0; t_view = 0; t_addr = 0; t_psel = 0;
    uio_in = 8'h00; ena = 1; rst_n = 0;
    clk_step(); clk_step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    t_wr = 1; t_en = 1; t_view = 0; t_addr = 0; t_psel = 0; uio_in = 8'h5A;
    ena = 1; rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      clk_step();
      n_checks++;
      if (uo_out !== 8'h00) begin
        n_errors++; $display("FAIL reset_count got %02h exp 00", uo_out);
      end
    end
    n_checks++;
    if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
      n_errors++; $display("FAIL reset_uio got %02h/%02h exp 00/00", uio_out, uio_oe);
    end
    t_en = 0; t_dir = 0;
    peek_view(1);
    n_checks++;
    if (uo_out !== 8'h00) begin
      n_errors++; $display("FAIL reset_status got %02h exp 00", uo_out);
    end
    peek_view(0);
  endtask

  task automatic test_full_wrap();
    apply_reset();
    t_en = 1; t_dir = 1;
    for (int k = 1; k <= 257; k++) begin
      clk_step();
      n_checks++;
      if (uo_out !== 8'(k % 256) || uo_out !== model_out()) begin
        n_errors++; $display("FAIL wrap_seq step %0d got %02h exp %02h", k, uo_out, 8'(k % 256));
      end
      if (k == 255 || k == 256) begin
        peek_view(1);
        n_checks++;
        if (uo_out !== ((k == 256) ? 8'hB0 : 8'h30)) begin
          n_errors++; $display("FAIL wrap_tc step %0d got %02h exp %02h", k, uo_out,
                               (k == 256) ? 8'hB0 : 8'h30);
        end
        peek_view(0);
      end
    end
  endtask

  task automatic test_modulo();
    apply_reset();
    do_write(1, 8'd9);
    do_write(0, 8'd0);
    t_en = 1; t_dir = 1;
    for (int k = 1; k <= 12; k++) begin
      clk_step();
      n_checks++;
      if (uo_out !== 8'(k % 10)) begin
        n_errors++; $display("FAIL mod9_seq step %0d got %02h exp %02h", k, uo_out, 8'(k % 10));
      end
    end
    peek_view(1);
    n_checks++;
    if (uo_out !== 8'hB0) begin
      n_errors++; $display("FAIL mod9_status got %02h exp b0", uo_out);
    end
    peek_view(0);
  endtask

  task automatic test_down_clear();
    apply_reset();
    do_write(1, 8'd9);
    do_write(0, 8'd0);
    t_en = 1; t_dir = 0;
    clk_step();
    n_checks++;
    if (uo_out !== 8'd9) begin
      n_errors++; $display("FAIL down_wrap got %02h exp 09", uo_out);
    end
    t_en = 0;
    peek_view(1);
    n_checks++;
    if (uo_out !== 8'h80) begin
      n_errors++; $display("FAIL down_tc got %02h exp 80", uo_out);
    end
    t_addr = 3; t_wr = 1;
    clk_step();
    n_checks++;
    if (uo_out !== 8'h00 || uo_out !== model_out()) begin
      n_errors++; $display("FAIL tc_clear got %02h exp 00", uo_out);
    end
    t_wr = 0; clk_step();
    peek_view(0);
  endtask

  task automatic test_prescale();
    apply_reset();
    t_en = 1; t_dir = 1; t_psel = 1;
    clk_step(); clk_step(); clk_step();
    t_addr = 0; uio_in = 8'd0; t_wr = 1;
    for (int j = 0; j <= 32; j++) begin
      if (j == 5) t_wr = 0;
      clk_step();
      if (j == 15 || j == 16 || j == 31 || j == 32) begin
        n_checks++;
        if (uo_out !== ((j < 16) ? 8'd0 : (j < 32) ? 8'd1 : 8'd2)) begin
          n_errors++; $display("FAIL presc16 j %0d got %02h", j, uo_out);
        end
      end
    end
    t_psel = 0;
  endtask

  task automatic test_pwm();
    int ones;
    apply_reset();
    do_write(1, 8'd9);
    do_write(2, 8'd3);
    do_write(0, 8'd0);
    n_checks++;
    if (uo_out !== 8'h00) begin
      n_errors++; $display("FAIL pwm_setup got %02h exp 00", uo_out);
    end
    t_en = 1; t_dir = 1; t_view = 1;
    ones = 0;
    for (int k = 0; k < 20; k++) begin
      clk_step();
      ones += int'(uo_out[6]);
      n_checks++;
      if (uo_out !== model_out()) begin
        n_errors++; $display("FAIL pwm_status step %0d got %02h exp %02h", k, uo_out, model_out());
      end
    end
    n_checks++;
`ifdef PWM_OUT_EN
    if (ones != 6) begin
      n_errors++; $display("FAIL pwm_duty got %0d exp 6", ones);
    end
`else
    if (ones != 0) begin
      n_errors++; $display("FAIL pwm_absent got %0d exp 0", ones);
    end
`endif
    t_view = 0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    t_en = 1; t_dir = 1;
    clk_step(); clk_step(); clk_step();
    t_addr = 0; uio_in = 8'd5; t_wr = 1;
    clk_step();
    n_checks++;
    if (uo_out !== 8'd5) begin
      n_errors++; $display("FAIL collide got %02h exp 05", uo_out);
    end
    t_wr = 0;
    clk_step();
    n_checks++;
    if (uo_out !== 8'd6) begin
      n_errors++; $display("FAIL after_collide got %02h exp 06", uo_out);
    end
    // Reset mid-count restores the full modulo
    t_en = 0; do_write(1, 8'd9); t_en = 1;
    for (int k = 0; k < 7; k++) clk_step();
    rst_n = 0;
    clk_step();
    n_checks++;
    if (uo_out !== 8'h00) begin
      n_errors++; $display("FAIL mid_reset got %02h exp 00", uo_out);
    end
    rst_n = 1;
    for (int k = 0; k < 12; k++) clk_step();
    n_checks++;
    if (uo_out !== 8'd12) begin
      n_errors++; $display("FAIL mod_reset got %02h exp 0c", uo_out);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      rst_n  = ($urandom_range(0, 299) != 0);
      ena    = ($urandom_range(0, 9) != 0);
      t_en   = ($urandom_range(0, 7) != 0);
      t_dir  = $urandom_range(0, 1);
      t_wr   = ($urandom_range(0, 3) == 0);
      t_view = $urandom_range(0, 1);
      t_addr = 2'($urandom_range(0, 3));
      t_psel = 2'($urandom_range(0, 3));
      uio_in = 8'($urandom);
      if (uio_in[7:6] != 2'b00 && t_addr == 1) uio_in = uio_in % 8'd40;
      clk_step();
      n_checks++;
      if (uo_out !== model_out()) begin
        n_errors++; $display("FAIL random step %0d got %02h exp %02h", i, uo_out, model_out());
      end
    end
  endtask

  initial begin
    t_en = 0; t_dir = 0; t_wr = 0; t_view = 0; t_addr = 0; t_psel = 0;
    uio_in = 8'h00; ena = 1; rst_n = 0;
    drive();
    test_reset();
    test_full_wrap();
    test_modulo();
    test_down_clear();
    test_prescale();
    test_pwm();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
